// File: rtl/mem_req_master.sv
// Initiator for the four-phase REQ/WEN/ACK memory handshake; sequences single/burst commands.
// Optional ACK timeout abort is built when MEM_REQ_MASTER_TIMEOUT_EN is defined.
module mem_req_master #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned LW       = 8,
  parameter int unsigned ADDR_INC = 2
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 255
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_WEN,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic [DW-1:0] CMD_WDATA,
  input  logic [LW-1:0] CMD_LEN,
  output logic          RSP_VALID,
  output logic [DW-1:0] RSP_DATA,
  output logic          RSP_LAST,
  output logic          DONE,
  output logic          ERR,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] DOUT,
  output logic          REQ,
  output logic          WEN,
  input  logic [DW-1:0] DIN,
  input  logic          ACK
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          done_q, done_d;
  logic [LW-1:0] beat_q, beat_d;

  logic          cmd_accept_c;
  logic          last_beat_c;
  logic          tmo_hit_c;

  assign CMD_READY    = (state_q == S_IDLE);
  assign cmd_accept_c = CMD_VALID && (state_q == S_IDLE);
  assign last_beat_c  = (beat_q == '0);

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      done_q      <= 1'b0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      done_q      <= done_d;
      beat_q      <= beat_d;
    end
  end

  // Next-state logic; ACK progress wins over a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (ACK)            state_d = S_RELEASE;
        else if (tmo_hit_c) state_d = S_IDLE;
      end
      S_RELEASE: begin
        if (!ACK)           state_d = last_beat_c ? S_IDLE : S_ASSERT;
        else if (tmo_hit_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered bus, response and completion outputs
  always_comb begin
    req_d       = req_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;
    done_d      = 1'b0;
    beat_d      = beat_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          addr_d = CMD_ADDR;
          dout_d = CMD_WDATA;
          wen_d  = CMD_WEN;
          beat_d = CMD_LEN;
          req_d  = 1'b1;
        end
      end
      S_ASSERT: begin
        if (ACK) begin
          req_d = 1'b0;
          if (!wen_q) begin
            rsp_data_d  = DIN;
            rsp_valid_d = 1'b1;
            rsp_last_d  = last_beat_c;
          end
        end else if (tmo_hit_c) begin
          req_d  = 1'b0;
          wen_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!ACK) begin
          if (!last_beat_c) begin
            beat_d = beat_q - LW'(1);
            addr_d = addr_q + AW'(ADDR_INC);
            req_d  = 1'b1;
          end else begin
            wen_d  = 1'b0;
            done_d = 1'b1;
          end
        end else if (tmo_hit_c) begin
          wen_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

`ifdef MEM_REQ_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Counter restarts on every state change, so it measures one wait phase
  assign tmo_hit_c = (tmo_q == TW'(TIMEOUT)) &&
                     (((state_q == S_ASSERT) && !ACK) || ((state_q == S_RELEASE) && ACK));

  always_comb begin
    tmo_d = '0;
    if ((state_q != S_IDLE) && (state_d == state_q)) tmo_d = tmo_q + TW'(1);
    err_d = err_q;
    if (cmd_accept_c)   err_d = 1'b0;
    else if (tmo_hit_c) err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign tmo_hit_c = 1'b0;
  assign ERR       = 1'b0;
`endif

  assign REQ       = req_q;
  assign WEN       = wen_q;
  assign ADDR      = addr_q;
  assign DOUT      = dout_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_LAST  = rsp_last_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: behavioural REQ/ACK memory slave plus response/beat scoreboards.
module tb_mem_req_master;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } rsp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] dout;
    logic        wen;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wen = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [7:0]  cmd_len = '0;
  logic        rsp_valid, rsp_last, done, err, req, wen;
  logic [15:0] rsp_data, addr, dout;
  logic [15:0] din = '0;
  logic        ack = 1'b0;

  int checks = 0;
  int passes = 0;

  rsp_t  rsp_q[$];
  beat_t beat_q[$];
  bit    done_allowed = 1'b0;

  mem_req_master dut (
    .CLK       (clk),
    .RST       (rst),
    .CMD_VALID (cmd_valid),
    .CMD_READY (cmd_ready),
    .CMD_WEN   (cmd_wen),
    .CMD_ADDR  (cmd_addr),
    .CMD_WDATA (cmd_wdata),
    .CMD_LEN   (cmd_len),
    .RSP_VALID (rsp_valid),
    .RSP_DATA  (rsp_data),
    .RSP_LAST  (rsp_last),
    .DONE      (done),
    .ERR       (err),
    .ADDR      (addr),
    .DOUT      (dout),
    .REQ       (req),
    .WEN       (wen),
    .DIN       (din),
    .ACK       (ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passes);
    $fatal(1);
  end

  // Memory slave: ACK rises rise_dly edges late, falls fall_dly edges late
  logic [15:0] mem [0:65535];
  int          rise_dly = 0;
  int          fall_dly = 0;
  bit          stuck = 1'b0;
  int          scnt = 0;

  always @(posedge clk) begin
    if (req && !ack && !stuck) begin
      if (scnt >= rise_dly) begin
        ack  <= 1'b1;
        scnt <= 0;
        if (wen) mem[addr] <= dout;
        else     din       <= mem[addr];
      end else begin
        scnt <= scnt + 1;
      end
    end else if (!req && ack) begin
      if (scnt >= fall_dly) begin
        ack  <= 1'b0;
        scnt <= 0;
      end else begin
        scnt <= scnt + 1;
      end
    end else begin
      scnt <= 0;
    end
  end

  logic ack_at_edge = 1'b0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    ack_at_edge <= ack;
    rst_at_edge <= rst;
  end

  logic        p_req = 1'b0;
  logic        p_wen = 1'b0;
  logic [15:0] p_addr = '0;
  logic [15:0] p_dout = '0;

  // Monitor: scoreboard pops and bus protocol checks, sampled mid-cycle
  always @(negedge clk) begin
    rsp_t  er;
    beat_t eb;
    if (rsp_valid) begin
      checks++;
      if (rsp_q.size() == 0) begin
        $display("FAIL rsp_unexpected: got data %h last %b, required no response", rsp_data, rsp_last);
      end else begin
        er = rsp_q.pop_front();
        if ({rsp_data, rsp_last} !== er)
          $display("FAIL rsp_data: got %h/%b, required %h/%b", rsp_data, rsp_last, er.data, er.last);
        else passes++;
      end
    end
    if (req && !p_req) begin
      checks++;
      if (ack_at_edge !== 1'b0) $display("FAIL req_rise_while_ack: got ack %b, required 0", ack_at_edge);
      else passes++;
      checks++;
      if (beat_q.size() == 0) begin
        $display("FAIL beat_unexpected: got addr %h dout %h wen %b, required no beat", addr, dout, wen);
      end else begin
        eb = beat_q.pop_front();
        if ({addr, dout, wen} !== eb)
          $display("FAIL beat: got %h/%h/%b, required %h/%h/%b", addr, dout, wen, eb.addr, eb.dout, eb.wen);
        else passes++;
      end
    end
    if (!req && p_req && !rst_at_edge && !err) begin
      checks++;
      if (ack_at_edge !== 1'b1) $display("FAIL req_early_drop: got ack %b at drop, required 1", ack_at_edge);
      else passes++;
    end
    if (req && p_req) begin
      checks++;
      if ({addr, dout, wen} !== {p_addr, p_dout, p_wen})
        $display("FAIL bus_stable: got %h/%h/%b, required %h/%h/%b", addr, dout, wen, p_addr, p_dout, p_wen);
      else passes++;
    end
    if (done && !done_allowed) begin
      checks++;
      $display("FAIL done_unexpected: got DONE 1, required 0");
    end
    p_req  = req;
    p_wen  = wen;
    p_addr = addr;
    p_dout = dout;
  end

  task automatic exp_beat(input logic [15:0] a, input logic [15:0] d, input logic w);
    beat_t b;
    b.addr = a;
    b.dout = d;
    b.wen  = w;
    beat_q.push_back(b);
  endtask

  task automatic exp_rsp(input logic [15:0] d, input logic l);
    rsp_t r;
    r.data = d;
    r.last = l;
    rsp_q.push_back(r);
  endtask

  // Issue one command; edges = accept-edge to DONE-visible count, -1 on expiry
  task automatic run_cmd(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [7:0] len, input int bound, output int edges,
                         output logic rdy_at_done, output logic err_at_done,
                         output logic err_after_accept);
    @(negedge clk);
    cmd_wen      = w;
    cmd_addr     = a;
    cmd_wdata    = d;
    cmd_len      = len;
    cmd_valid    = 1'b1;
    done_allowed = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid        = 1'b0;
    cmd_addr         = 16'($urandom);
    cmd_wdata        = 16'($urandom);
    err_after_accept = err;
    edges            = -1;
    rdy_at_done      = 1'b0;
    err_at_done      = 1'b0;
    for (int k = 0; k <= bound; k++) begin
      if (done) begin
        edges       = k;
        rdy_at_done = cmd_ready;
        err_at_done = err;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    done_allowed = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req, wen, rsp_valid, rsp_last, done, err} !== 6'b0)
      $display("FAIL reset_flags: got %b, required 000000", {req, wen, rsp_valid, rsp_last, done, err});
    else passes++;
    checks++;
    if ({addr, dout, rsp_data} !== 48'h0)
      $display("FAIL reset_buses: got %h/%h/%h, required 0/0/0", addr, dout, rsp_data);
    else passes++;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", cmd_ready);
    else passes++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    int   e;
    logic rdy, ed, ea;
    exp_beat(16'h0001, 16'h0002, 1'b1);
    run_cmd(1'b1, 16'h0001, 16'h0002, 8'd0, 100, e, rdy, ed, ea);
    checks++;
    if (e !== 4) $display("FAIL wr_done_edges: got %0d, required 4", e);
    else passes++;
    checks++;
    if (ed !== 1'b0) $display("FAIL wr_err: got %b, required 0", ed);
    else passes++;
    exp_beat(16'h0001, 16'h0000, 1'b0);
    exp_rsp(16'h0002, 1'b1);
    run_cmd(1'b0, 16'h0001, 16'h0000, 8'd0, 100, e, rdy, ed, ea);
    checks++;
    if (e !== 4) $display("FAIL rd_done_edges: got %0d, required 4", e);
    else passes++;
    checks++;
    if (rdy !== 1'b1) $display("FAIL rd_ready_at_done: got %b, required 1", rdy);
    else passes++;
    checks++;
    if (rsp_data !== 16'h0002) $display("FAIL rd_data_held: got %h, required 0002", rsp_data);
    else passes++;
  endtask

  task automatic test_burst_read();
    int   e;
    logic rdy, ed, ea;
    logic [15:0] vals [4];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      exp_beat(16'(16'h0010 + 2 * i), vals[i], 1'b1);
      run_cmd(1'b1, 16'(16'h0010 + 2 * i), vals[i], 8'd0, 100, e, rdy, ed, ea);
    end
    for (int i = 0; i < 4; i++) begin
      exp_beat(16'(16'h0010 + 2 * i), 16'h0000, 1'b0);
      exp_rsp(vals[i], i == 3);
    end
    run_cmd(1'b0, 16'h0010, 16'h0000, 8'd3, 200, e, rdy, ed, ea);
    checks++;
    if (e !== 16) $display("FAIL burst_done_edges: got %0d, required 16", e);
    else passes++;
    checks++;
    if (rsp_q.size() !== 0) $display("FAIL burst_rsp_left: got %0d pending, required 0", rsp_q.size());
    else passes++;
  endtask

  task automatic test_wrap();
    int   e;
    logic rdy, ed, ea;
    exp_beat(16'hFFFE, 16'hA5A5, 1'b1);
    exp_beat(16'h0000, 16'hA5A5, 1'b1);
    run_cmd(1'b1, 16'hFFFE, 16'hA5A5, 8'd1, 100, e, rdy, ed, ea);
    checks++;
    if (e !== 8) $display("FAIL wrap_done_edges: got %0d, required 8", e);
    else passes++;
    checks++;
    if (rsp_data !== 16'h4444) $display("FAIL wrap_rsp_untouched: got %h, required 4444", rsp_data);
    else passes++;
    exp_beat(16'h0000, 16'h0000, 1'b0);
    exp_rsp(16'hA5A5, 1'b1);
    run_cmd(1'b0, 16'h0000, 16'h0000, 8'd0, 100, e, rdy, ed, ea);
    exp_beat(16'hFFFE, 16'h0000, 1'b0);
    exp_rsp(16'hA5A5, 1'b1);
    run_cmd(1'b0, 16'hFFFE, 16'h0000, 8'd0, 100, e, rdy, ed, ea);
    checks++;
    if (rsp_data !== 16'hA5A5) $display("FAIL wrap_readback: got %h, required a5a5", rsp_data);
    else passes++;
  endtask

  task automatic test_handshake();
    int   e;
    logic rdy, ed, ea;
    rise_dly = 7;
    fall_dly = 3;
    exp_beat(16'h0100, 16'hBEEF, 1'b1);
    exp_beat(16'h0102, 16'hBEEF, 1'b1);
    run_cmd(1'b1, 16'h0100, 16'hBEEF, 8'd1, 200, e, rdy, ed, ea);
    checks++;
    if (e !== 28) $display("FAIL slow_wr_edges: got %0d, required 28", e);
    else passes++;
    exp_beat(16'h0100, 16'h0000, 1'b0);
    exp_beat(16'h0102, 16'h0000, 1'b0);
    exp_rsp(16'hBEEF, 1'b0);
    exp_rsp(16'hBEEF, 1'b1);
    run_cmd(1'b0, 16'h0100, 16'h0000, 8'd1, 200, e, rdy, ed, ea);
    checks++;
    if (e !== 28) $display("FAIL slow_rd_edges: got %0d, required 28", e);
    else passes++;
    rise_dly = 0;
    fall_dly = 0;
  endtask

  task automatic test_reset_mid_burst();
    int   rises = 0;
    logic pr;
    for (int i = 0; i < 4; i++) begin
      exp_beat(16'(16'h0010 + 2 * i), 16'h0000, 1'b0);
      exp_rsp(16'(16'h1111 * (i + 1)), i == 3);
    end
    @(negedge clk);
    cmd_wen   = 1'b0;
    cmd_addr  = 16'h0010;
    cmd_wdata = 16'h0000;
    cmd_len   = 8'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    pr = req;
    for (int k = 0; k < 50 && rises == 0; k++) begin
      @(negedge clk);
      if (req && !pr) rises++;
      pr = req;
    end
    checks++;
    if (rises !== 1) $display("FAIL rst_beat2_seen: got %0d rises, required 1", rises);
    else passes++;
    rst = 1'b1;
    @(posedge clk);
    checks++;
    if (rsp_q.size() !== 3) $display("FAIL rst_pre_rsp: got %0d pending, required 3", rsp_q.size());
    else passes++;
    rsp_q.delete();
    beat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req !== 1'b0) $display("FAIL rst_req: got %b, required 0", req);
    else passes++;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b, required 1", cmd_ready);
    else passes++;
    repeat (10) @(negedge clk);
  endtask

`ifdef MEM_REQ_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int   e;
    logic rdy, ed, ea;
    stuck = 1'b1;
    exp_beat(16'h0200, 16'h0000, 1'b0);
    run_cmd(1'b0, 16'h0200, 16'h0000, 8'd2, 400, e, rdy, ed, ea);
    checks++;
    if (e !== 256) $display("FAIL tmo_edges: got %0d, required 256", e);
    else passes++;
    checks++;
    if (ed !== 1'b1) $display("FAIL tmo_err: got %b, required 1", ed);
    else passes++;
    checks++;
    if ({req, cmd_ready} !== 2'b01) $display("FAIL tmo_idle: got req/ready %b, required 01", {req, cmd_ready});
    else passes++;
    stuck = 1'b0;
    exp_beat(16'h0300, 16'h1234, 1'b1);
    run_cmd(1'b1, 16'h0300, 16'h1234, 8'd0, 100, e, rdy, ed, ea);
    checks++;
    if (ea !== 1'b0) $display("FAIL tmo_err_clear: got %b, required 0", ea);
    else passes++;
    checks++;
    if (e !== 4) $display("FAIL tmo_recover_edges: got %0d, required 4", e);
    else passes++;
  endtask
`endif

  task automatic test_end();
    checks++;
    if (rsp_q.size() !== 0) $display("FAIL end_rsp_queue: got %0d pending, required 0", rsp_q.size());
    else passes++;
    checks++;
    if (beat_q.size() !== 0) $display("FAIL end_beat_queue: got %0d pending, required 0", beat_q.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_burst_read();
    test_wrap();
    test_handshake();
    test_reset_mid_burst();
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_end();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
